// File: rtl/four_bit_seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on operands and product.
// Optional macro MUL_ZERO_SKIP_EN finalises early once all remaining multiplier bits are zero.
module four_bit_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_next;
    logic [WIDTH:0]       acc, acc_next, sum;
    logic [WIDTH-1:0]     mcand, mplier, mplier_next;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic [2*WIDTH-1:0]   prod_next;

`ifdef MUL_ZERO_SKIP_EN
    logic [CW-1:0]        rem;
    logic [WIDTH-1:0]     unproc_mask;
    logic [2*WIDTH:0]     wide;
`endif

    // One iteration: conditional add, then shift {acc,mplier} right by one.
    // acc[WIDTH] is always zero entering an iteration, so adding the full acc is safe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sum         = acc + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next    = {1'b0, sum[WIDTH:1]};
        mplier_next = {sum[0], mplier[WIDTH-1:1]};
        prod_next   = {acc_next[WIDTH-1:0], mplier_next};
        last        = (cnt == CW'(WIDTH - 1));
`ifdef MUL_ZERO_SKIP_EN
        rem         = CW'(WIDTH) - cnt;
        unproc_mask = {WIDTH{1'b1}} >> cnt;
        wide        = {acc, mplier} >> rem;
        if ((mplier & unproc_mask) == '0) begin
            last      = 1'b1;
            prod_next = wide[2*WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            P      <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        P   <= prod_next;
                        ovf <= |prod_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_seq_multiplier.sv
// Self-checking bench for four_bit_seq_multiplier: directed cases, exhaustive sweep and random ops
// against an arithmetic reference model.
module tb_four_bit_seq_multiplier;

    localparam int WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    four_bit_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to out_valid, derived from the operand value alone.
    function automatic int exp_latency(input int bv);
`ifdef MUL_ZERO_SKIP_EN
        int msb = -1;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) msb = i;
        if (bv == 0) return 1;
        return (msb + 2 < WIDTH) ? msb + 2 : WIDTH;
`else
        return WIDTH + 0 * bv;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int av, input int bv, input int stall, input bit poke, input string tag);
        int prod;
        int lat;
        int guard;
        prod  = av * bv;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1);
        a        = av[3:0];
        b        = bv[3:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_latency(bv));
        check({tag, "_P"}, p, prod);
        check({tag, "_ovf"}, ovf, (prod > 15) ? 1 : 0);
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin
                a        = 4'h1;
                b        = 4'h1;
                in_valid = 1'b1;
                check({tag, "_in_ready_done"}, in_ready, 0);
            end
            step();
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_P"}, p, prod);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_taken_valid"}, out_valid, 0);
        check({tag, "_taken_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_P", p, 0);
        check("reset_ovf", ovf, 0);
        step();
        rst_n = 1'b1;
        step();

        run_op(3, 5, 0, 1'b0, "a3b5");
        run_op(15, 15, 0, 1'b0, "aFbF");
        run_op(8, 2, 0, 1'b0, "a8b2");
        run_op(7, 2, 0, 1'b0, "a7b2");
        run_op(9, 0, 0, 1'b0, "b0");
        run_op(12, 1, 0, 1'b0, "aCb1");
        run_op(11, 8, 0, 1'b0, "b8");

        // Backpressure with an ignored in_valid pulse while DONE.
        run_op(9, 6, 5, 1'b1, "bp");
        step();
        step();
        check("bp_no_ghost_op", out_valid, 0);
        check("bp_still_idle", in_ready, 1);
        check("bp_P_kept", p, 8'h36);

        // Asynchronous reset during the second iteration.
        a        = 4'hB;
        b        = 4'hD;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_P", p, 0);
        check("midrst_ovf", ovf, 0);
        step();
        rst_n = 1'b1;
        step();
        check("midrst_no_output", out_valid, 0);
        run_op(2, 2, 0, 1'b0, "post_rst");

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                run_op(ia, ib, int'($urandom_range(0, 2)), 1'b0, "sweep");

        for (int k = 0; k < 24; k++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b0, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
